// File: rtl/shared_vc_pool_ctrl_pkg.sv
// Shared VC pool controller: common types.
// Per-VC lifecycle encodings used by the top level.
package shared_vc_pool_ctrl_pkg;

  typedef enum logic [1:0] {
    VC_FREE  = 2'd0,
    VC_ALLOC = 2'd1,
    VC_DRAIN = 2'd2
  } vc_state_e;

endpackage

// File: rtl/shared_vc_pool_ctrl_rr_arb.sv
// Round-robin arbiter for the shared VC pool.
// Holds the rotating priority pointer and picks one winner.
module shared_vc_rr_arb #(
  parameter int num_ports = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [num_ports-1:0] req,
  input  logic                 en,
  output logic [num_ports-1:0] gnt,
  output logic                 valid
);

  localparam int pw = (num_ports > 1) ? $clog2(num_ports) : 1;

  logic [pw-1:0] ptr_q;
  logic [pw-1:0] win_idx;
  logic [pw-1:0] cand;
  logic          found;
  int            idx;

  // Scan requesters starting at the pointer; first hit wins.
  always_comb begin
    found   = 1'b0;
    win_idx = ptr_q;
    idx     = 0;
    cand    = '0;
    for (int i = 0; i < num_ports; i++) begin
      idx  = (int'(ptr_q) + i) % num_ports;
      cand = pw'(idx);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  // One-hot grant, only when the pool has a free VC.
  always_comb begin
    gnt   = '0;
    valid = en && found;
    if (valid) gnt[win_idx] = 1'b1;
  end

  // Pointer moves past the winner; holds without a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (valid) begin
      if (win_idx == pw'(num_ports - 1)) ptr_q <= '0;
      else ptr_q <= win_idx + pw'(1);
    end
  end

endmodule

// File: rtl/shared_vc_pool_ctrl.sv
// Shared output-VC pool controller: allocation, credits, drain.
// VC state and credit counters live here; arbitration is delegated.
module shared_vc_pool_ctrl
  import shared_vc_pool_ctrl_pkg::*;
#(
  parameter int num_ports      = 5,
  parameter int num_shared_vcs = 4,
  parameter int credit_depth   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [num_ports-1:0]      alloc_req_ip,
  output logic [num_ports-1:0]      alloc_gnt_ip,
  output logic [num_shared_vcs-1:0] alloc_sel_ovc,
  input  logic                      flit_sent_valid,
  input  logic [num_shared_vcs-1:0] flit_sent_ovc,
  input  logic                      flit_sent_tail,
  input  logic                      credit_valid,
  input  logic [num_shared_vcs-1:0] credit_ovc,
  output logic [num_shared_vcs-1:0] elig_op_shared_ovc,
  output logic [num_shared_vcs-1:0] credit_avail_ovc,
  output logic                      shared_vc_active_op,
  output logic                      error
);

  localparam int nv = num_shared_vcs;
  localparam int cw = $clog2(credit_depth + 1);
  localparam logic [cw-1:0] full_cnt = cw'(credit_depth);

  vc_state_e     state_q [nv];
  vc_state_e     state_d [nv];
  logic [cw-1:0] cnt_q   [nv];
  logic [cw-1:0] cnt_d   [nv];

  logic [nv-1:0]        free_vec;
  logic [nv-1:0]        low_free;
  logic [nv-1:0]        snd;
  logic [nv-1:0]        ret;
  logic [num_ports-1:0] arb_gnt;
  logic                 arb_valid;
  logic                 any_free;
  logic                 err_set;

  assign snd      = {nv{flit_sent_valid}} & flit_sent_ovc;
  assign ret      = {nv{credit_valid}} & credit_ovc;
  assign any_free = |free_vec;
  assign low_free = free_vec & (~free_vec + nv'(1));

  shared_vc_rr_arb #(
    .num_ports(num_ports)
  ) u_arb (
    .clk  (clk),
    .reset(reset),
    .req  (alloc_req_ip),
    .en   (any_free),
    .gnt  (arb_gnt),
    .valid(arb_valid)
  );

  // Free-VC vector from registered state.
  always_comb begin
    free_vec = '0;
    for (int v = 0; v < nv; v++)
      free_vec[v] = (state_q[v] == VC_FREE);
  end

  // Next VC state, credit count and protocol-error detection.
  always_comb begin
    err_set = 1'b0;
    for (int v = 0; v < nv; v++) begin
      state_d[v] = state_q[v];
      cnt_d[v]   = cnt_q[v];
      if (snd[v] && !ret[v]) begin
        if (cnt_q[v] == '0) err_set = 1'b1;
        else cnt_d[v] = cnt_q[v] - cw'(1);
      end else if (ret[v] && !snd[v]) begin
        if (cnt_q[v] == full_cnt) err_set = 1'b1;
        else cnt_d[v] = cnt_q[v] + cw'(1);
      end
      unique case (state_q[v])
        VC_FREE: begin
          if (snd[v]) err_set = 1'b1;
          if (arb_valid && low_free[v]) state_d[v] = VC_ALLOC;
        end
        VC_ALLOC: begin
          if (snd[v] && flit_sent_tail) state_d[v] = VC_DRAIN;
        end
        VC_DRAIN: begin
          if (cnt_q[v] == full_cnt) state_d[v] = VC_FREE;
        end
        default: state_d[v] = VC_FREE;
      endcase
    end
  end

  // State, credit, grant and sticky-error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_gnt_ip  <= '0;
      alloc_sel_ovc <= '0;
      error         <= 1'b0;
      for (int v = 0; v < nv; v++) begin
        state_q[v] <= VC_FREE;
        cnt_q[v]   <= full_cnt;
      end
    end else begin
      alloc_gnt_ip  <= arb_gnt;
      alloc_sel_ovc <= arb_valid ? low_free : '0;
      error         <= error | err_set;
      for (int v = 0; v < nv; v++) begin
        state_q[v] <= state_d[v];
        cnt_q[v]   <= cnt_d[v];
      end
    end
  end

  // Status outputs decoded from registered state.
  always_comb begin
    elig_op_shared_ovc = '0;
    credit_avail_ovc   = '0;
    for (int v = 0; v < nv; v++) begin
      elig_op_shared_ovc[v] = (state_q[v] == VC_FREE) &&
                              (cnt_q[v] == full_cnt);
      credit_avail_ovc[v]   = (cnt_q[v] != '0);
    end
    shared_vc_active_op = (~&free_vec) | (|alloc_req_ip);
  end

endmodule
